ebi_cmd_dispatcher: RTL and testbench

- Consumer end of the 64-bit command FIFO that the EBI interface fills, four 16-bit host words per entry.
- Pops one entry at a time and decodes its opcode.
- Issues single write transactions on the internal register bus, or executes local timing and no-op commands.
- Sits between the command FIFO read port and the pin/sampling controllers. Provides the host with a busy flag and an error counter.

---
 rtl/ebi_cmd_pkg.sv | 33 +++
 rtl/ebi_cmd_dispatcher_sat_counter.sv | 29 ++
 rtl/ebi_cmd_dispatcher.sv | 159 +++++++++++++++
 tb/tb_ebi_cmd_dispatcher.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ebi_cmd_pkg.sv
// ebi_cmd_pkg
// Shared definitions for the EBI command path. Firmware header generation
// and the EBI word-ordering logic read the same constants, so any change here
// changes the host-visible command format.
//   - opcode values carried in bits [63:56] of a command entry
//   - bit positions of the command fields
//   - FSM state encoding of the command dispatcher
package ebi_cmd_pkg;

    // Opcodes
    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_WRITE   = 8'h01;
    localparam logic [7:0] OP_WAIT    = 8'h02;
    localparam logic [7:0] OP_CLR_ERR = 8'h03;

    // Command entry field positions (word 1 of the host write is [63:48])
    localparam int CMD_OP_HI   = 63;
    localparam int CMD_OP_LO   = 56;
    localparam int CMD_ADDR_HI = 55;
    localparam int CMD_ADDR_LO = 48;
    localparam int CMD_RSV_HI  = 47;
    localparam int CMD_RSV_LO  = 32;
    localparam int CMD_DATA_HI = 31;
    localparam int CMD_DATA_LO = 0;

    // Dispatcher FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_ISSUE  = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;

endpackage

// File: rtl/ebi_cmd_dispatcher_sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous clear. Sticks at all-ones instead of
// wrapping, so a long burst of errors can never read back as a small number.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset
//   clr   - synchronous clear (same effect as reset)
//   inc   - count one event this cycle
//   count - current value, W bits
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear dominates increment; increment is dropped once saturated.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ebi_cmd_dispatcher.sv
// ebi_cmd_dispatcher
// Consumer of the 64-bit EBI command FIFO. Pops one entry at a time, decodes
// the opcode and either issues a single register-bus write, stalls for a
// number of cycles, clears the error counter, or does nothing.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   cmd_fifo_data_out  - FIFO read data (valid in FETCH)
//   cmd_fifo_empty     - FIFO empty flag, looked at only in IDLE
//   cmd_fifo_rd_en     - one-cycle pop strobe
//   bus_addr/bus_data  - write address/data, held after the transaction
//   bus_req            - write request, held until ack or timeout
//   bus_ack            - single-cycle accept pulse from the slave
//   busy               - high whenever the FSM is not in IDLE
//   err_count          - saturating count of bad opcodes and bus timeouts
module ebi_cmd_dispatcher
    import ebi_cmd_pkg::*;
#(
    parameter int ACK_TIMEOUT = 64,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      cmd_fifo_data_out,
    input  logic             cmd_fifo_empty,
    output logic             cmd_fifo_rd_en,
    output logic [7:0]       bus_addr,
    output logic [31:0]      bus_data,
    output logic             bus_req,
    input  logic             bus_ack,
    output logic             busy,
    output logic [ERR_W-1:0] err_count
);

    localparam int              TO_W   = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(ACK_TIMEOUT - 1);

    logic [2:0]      state;
    logic [2:0]      state_next;
    logic [7:0]      op_q;
    logic [7:0]      addr_q;
    logic [31:0]     data_q;
    logic [31:0]     wait_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            err_inc;
    logic            err_clr;

    // Reserved command bits carry no meaning; reduced here only so they are
    // visibly consumed.
    logic reserved_unused;
    assign reserved_unused = ^cmd_fifo_data_out[CMD_RSV_HI:CMD_RSV_LO];

    // Next-state and error-event decode. An ack arriving in the same cycle
    // as the timeout wins, so a late-but-valid ack is never counted as error.
    always_comb begin
        state_next = state;
        err_inc    = 1'b0;
        err_clr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!cmd_fifo_empty) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (op_q)
                    OP_WRITE:   state_next = ST_ISSUE;
                    OP_WAIT:    state_next = (data_q == 32'd0) ? ST_IDLE : ST_WAIT;
                    OP_NOP:     state_next = ST_IDLE;
                    OP_CLR_ERR: begin
                        err_clr    = 1'b1;
                        state_next = ST_IDLE;
                    end
                    default: begin
                        err_inc    = 1'b1;
                        state_next = ST_IDLE;
                    end
                endcase
            end
            ST_ISSUE: begin
                if (bus_ack) begin
                    state_next = ST_IDLE;
                end else if (to_cnt == TO_MAX) begin
                    err_inc    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 32'd1) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, registered outputs and inline counters. busy is derived from the
    // next state so it lines up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            cmd_fifo_rd_en <= 1'b0;
            bus_req        <= 1'b0;
            bus_addr       <= 8'd0;
            bus_data       <= 32'd0;
            busy           <= 1'b0;
            op_q           <= 8'd0;
            addr_q         <= 8'd0;
            data_q         <= 32'd0;
            wait_cnt       <= 32'd0;
            to_cnt         <= '0;
        end else begin
            state          <= state_next;
            busy           <= (state_next != ST_IDLE);
            cmd_fifo_rd_en <= (state == ST_IDLE) && !cmd_fifo_empty;
            case (state)
                ST_FETCH: begin
                    op_q   <= cmd_fifo_data_out[CMD_OP_HI:CMD_OP_LO];
                    addr_q <= cmd_fifo_data_out[CMD_ADDR_HI:CMD_ADDR_LO];
                    data_q <= cmd_fifo_data_out[CMD_DATA_HI:CMD_DATA_LO];
                end
                ST_DECODE: begin
                    if (op_q == OP_WRITE) begin
                        bus_addr <= addr_q;
                        bus_data <= data_q;
                        bus_req  <= 1'b1;
                        to_cnt   <= '0;
                    end
                    if (op_q == OP_WAIT) begin
                        wait_cnt <= data_q;
                    end
                end
                ST_ISSUE: begin
                    if (bus_ack || (to_cnt == TO_MAX)) begin
                        bus_req <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 32'd1;
                end
                default: begin
                end
            endcase
        end
    end

    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (err_clr),
        .inc  (err_inc),
        .count(err_count)
    );

endmodule

// File: tb/tb_ebi_cmd_dispatcher.sv
// tb_ebi_cmd_dispatcher
// Directed bench for ebi_cmd_dispatcher: a queue-backed command FIFO model,
// a register-bus slave with programmable ack delay, and a negedge monitor
// that records pop cycles, request lengths and acknowledged addresses.
module tb_ebi_cmd_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] fifo_data = 64'd0;
    logic        fifo_empty = 1'b1;
    logic        rd_en;
    logic [7:0]  bus_addr;
    logic [31:0] bus_data;
    logic        bus_req;
    logic        bus_ack = 1'b0;
    logic        busy;
    logic [7:0]  err_count;

    logic [63:0] fifo_q[$];
    int          total = 0;
    int          bad = 0;

    // Monitor state
    int          cyc = 0;
    int          pop_times[$];
    logic [7:0]  acked_addr[$];
    int          b2b = 0;
    logic        prev_rd = 1'b0;
    logic        prev_busy = 1'b0;
    int          busy_fall = 0;
    int          req_cnt = 0;
    int          last_req_len = 0;
    int          ack_delay = 0;

    ebi_cmd_dispatcher #(
        .ACK_TIMEOUT(64),
        .ERR_W      (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_fifo_data_out(fifo_data),
        .cmd_fifo_empty   (fifo_empty),
        .cmd_fifo_rd_en   (rd_en),
        .bus_addr         (bus_addr),
        .bus_data         (bus_data),
        .bus_req          (bus_req),
        .bus_ack          (bus_ack),
        .busy             (busy),
        .err_count        (err_count)
    );

    always #5 clk = ~clk;

    // FIFO model: head is presented on the data port, popped on rd_en.
    always @(posedge clk) begin
        if (rd_en && fifo_q.size() != 0) void'(fifo_q.pop_front());
        fifo_empty <= (fifo_q.size() == 0);
        fifo_data  <= (fifo_q.size() != 0) ? fifo_q[0] : 64'd0;
    end

    // Slave model and monitor, evaluated mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rd_en) begin
                pop_times.push_back(cyc);
                if (prev_rd) b2b++;
            end
            prev_rd = rd_en;
            if (prev_busy && !busy) busy_fall = cyc;
            prev_busy = busy;
            if (bus_req) begin
                req_cnt++;
            end else begin
                if (req_cnt != 0) last_req_len = req_cnt;
                req_cnt = 0;
            end
            bus_ack = bus_req && (ack_delay >= 0) && (req_cnt == ack_delay + 1);
            if (bus_ack) acked_addr.push_back(bus_addr);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] cmd);
        fifo_q.push_back(cmd);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        repeat (3) tick();
        n = 0;
        while (!(!busy && !rd_en && fifo_empty && fifo_q.size() == 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) checkOutput("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic waitReq(input logic level, input int budget);
        int n;
        n = 0;
        while (bus_req !== level && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) checkOutput("req_timeout", {63'd0, bus_req}, {63'd0, level});
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        $display("[TB] reset state");
        checkOutput("rst_rd_en", {63'd0, rd_en}, 64'd0);
        checkOutput("rst_req", {63'd0, bus_req}, 64'd0);
        checkOutput("rst_addr", {56'd0, bus_addr}, 64'd0);
        checkOutput("rst_data", {32'd0, bus_data}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_err", {56'd0, err_count}, 64'd0);
        rst = 1'b0;
        tick();

        $display("[TB] single write, ack 2 cycles after req");
        ack_delay = 2;
        applyStimulus(64'h0105_0000_DEADBEEF);
        waitIdle(200);
        checkOutput("w1_addr", {56'd0, bus_addr}, 64'h05);
        checkOutput("w1_data", {32'd0, bus_data}, 64'hDEADBEEF);
        checkOutput("w1_req_len", 64'(last_req_len), 64'd3);
        checkOutput("w1_err", {56'd0, err_count}, 64'd0);
        checkOutput("w1_busy", {63'd0, busy}, 64'd0);

        $display("[TB] wait 10 then nop");
        pop_times.delete();
        applyStimulus(64'h0200_0000_0000000A);
        applyStimulus(64'h0000_0000_00000000);
        waitIdle(200);
        checkOutput("wait10_pops", 64'(pop_times.size()), 64'd2);
        if (pop_times.size() == 2)
            checkOutput("wait10_gap", 64'(pop_times[1] - pop_times[0]), 64'd13);

        $display("[TB] wait 0 then nop");
        pop_times.delete();
        applyStimulus(64'h0200_0000_00000000);
        applyStimulus(64'h0000_FFFF_00000000);
        waitIdle(200);
        checkOutput("wait0_pops", 64'(pop_times.size()), 64'd2);
        if (pop_times.size() == 2)
            checkOutput("wait0_gap", 64'(pop_times[1] - pop_times[0]), 64'd3);
        checkOutput("nop_err", {56'd0, err_count}, 64'd0);

        $display("[TB] write timeout then queued write");
        ack_delay = -1;
        applyStimulus(64'h0133_0000_11111111);
        applyStimulus(64'h0144_0000_22222222);
        waitReq(1'b1, 50);
        waitReq(1'b0, 100);
        checkOutput("to_req_len", 64'(last_req_len), 64'd64);
        checkOutput("to_err", {56'd0, err_count}, 64'd1);
        checkOutput("to_addr_hold", {56'd0, bus_addr}, 64'h33);
        ack_delay = 0;
        waitIdle(200);
        checkOutput("to_next_addr", {56'd0, bus_addr}, 64'h44);
        checkOutput("to_next_data", {32'd0, bus_data}, 64'h22222222);
        checkOutput("to_next_err", {56'd0, err_count}, 64'd1);

        $display("[TB] illegal opcode saturation and clear");
        applyStimulus(64'h0300_0000_00000000);
        waitIdle(200);
        checkOutput("clr1_err", {56'd0, err_count}, 64'd0);
        for (int i = 0; i < 300; i++) applyStimulus(64'h7F00_0000_00000000);
        waitIdle(2000);
        checkOutput("sat_err", {56'd0, err_count}, 64'd255);
        applyStimulus(64'h0300_0000_00000000);
        waitIdle(200);
        checkOutput("clr2_err", {56'd0, err_count}, 64'd0);
        applyStimulus(64'h0400_0000_00000000);
        waitIdle(200);
        checkOutput("op04_err", {56'd0, err_count}, 64'd1);

        $display("[TB] three writes back to back, immediate ack");
        pop_times.delete();
        acked_addr.delete();
        b2b = 0;
        ack_delay = 0;
        applyStimulus(64'h01A1_0000_000000A1);
        applyStimulus(64'h01A2_FFFF_000000A2);
        applyStimulus(64'h01A3_0000_000000A3);
        waitIdle(200);
        checkOutput("b2b_pops", 64'(pop_times.size()), 64'd3);
        checkOutput("b2b_consec", 64'(b2b), 64'd0);
        if (pop_times.size() == 3) begin
            checkOutput("b2b_gap1", 64'(pop_times[1] - pop_times[0]), 64'd4);
            checkOutput("b2b_gap2", 64'(pop_times[2] - pop_times[1]), 64'd4);
            checkOutput("b2b_drain", 64'(busy_fall - pop_times[0]), 64'd11);
        end
        checkOutput("b2b_acks", 64'(acked_addr.size()), 64'd3);
        if (acked_addr.size() == 3) begin
            checkOutput("b2b_ord0", {56'd0, acked_addr[0]}, 64'hA1);
            checkOutput("b2b_ord1", {56'd0, acked_addr[1]}, 64'hA2);
            checkOutput("b2b_ord2", {56'd0, acked_addr[2]}, 64'hA3);
        end
        checkOutput("b2b_data", {32'd0, bus_data}, 64'hA3);
        checkOutput("b2b_err", {56'd0, err_count}, 64'd1);

        $display("[TB] reset mid-issue");
        ack_delay = -1;
        applyStimulus(64'h0155_0000_55555555);
        applyStimulus(64'h0166_0000_66666666);
        waitReq(1'b1, 50);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checkOutput("mr_req", {63'd0, bus_req}, 64'd0);
        checkOutput("mr_busy", {63'd0, busy}, 64'd0);
        checkOutput("mr_err", {56'd0, err_count}, 64'd0);
        checkOutput("mr_addr", {56'd0, bus_addr}, 64'd0);
        rst = 1'b0;
        ack_delay = 0;
        waitIdle(200);
        checkOutput("mr_next_addr", {56'd0, bus_addr}, 64'h66);
        checkOutput("mr_next_data", {32'd0, bus_data}, 64'h66666666);
        checkOutput("mr_next_err", {56'd0, err_count}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
